// File: rtl/overture_pkg.sv
// Shared types and constants for the overture_cpu 8-bit accumulator core.
package overture_pkg;

  typedef enum logic [1:0] {
    OP_IMM  = 2'b00,
    OP_CALC = 2'b01,
    OP_COPY = 2'b10,
    OP_JUMP = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_OR    = 3'd0,
    ALU_NAND  = 3'd1,
    ALU_NOR   = 3'd2,
    ALU_AND   = 3'd3,
    ALU_ADD   = 3'd4,
    ALU_SUB   = 3'd5,
    ALU_ZERO6 = 3'd6,
    ALU_ZERO7 = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    C_NEVER  = 3'd0,
    C_EQZ    = 3'd1,
    C_LTZ    = 3'd2,
    C_LEZ    = 3'd3,
    C_ALWAYS = 3'd4,
    C_NEZ    = 3'd5,
    C_GEZ    = 3'd6,
    C_GTZ    = 3'd7
  } cond_t;

  localparam logic [2:0] IO_REG   = 3'd6;
  localparam logic [2:0] ZERO_REG = 3'd7;

endpackage

// File: rtl/overture_alu.sv
// Combinational ALU (r1 op r2) and jump-condition evaluator on signed r3.
module overture_alu
  import overture_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  alu_op_t    op_i,
  output logic [7:0] result_o,
  input  logic [7:0] cond_val_i,
  input  cond_t      cond_i,
  output logic       taken_o
);

  logic neg;
  logic zero;

  assign neg  = cond_val_i[7];
  assign zero = (cond_val_i == 8'h00);

  always_comb begin
    result_o = 8'h00;
    case (op_i)
      ALU_OR:   result_o = a_i | b_i;
      ALU_NAND: result_o = ~(a_i & b_i);
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_AND:  result_o = a_i & b_i;
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      default:  result_o = 8'h00;
    endcase
  end

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      C_NEVER:  taken_o = 1'b0;
      C_EQZ:    taken_o = zero;
      C_LTZ:    taken_o = neg;
      C_LEZ:    taken_o = neg | zero;
      C_ALWAYS: taken_o = 1'b1;
      C_NEZ:    taken_o = ~zero;
      C_GEZ:    taken_o = ~neg;
      C_GTZ:    taken_o = ~neg & ~zero;
      default:  taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/overture_cpu.sv
// overture_cpu: one-instruction-per-clock core fed by a combinational ROM.
// Define OVERTURE_IO_EN to turn register 6 into the in/out I/O port.
module overture_cpu
  import overture_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] address,
  input  logic [7:0] dataout,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic [7:0] reg3
);

  logic [7:0] pc_q, pc_d;
  logic [7:0] regs_q [0:6];
  logic [7:0] regs_d [0:6];

  opcode_t    opcode;
  logic [2:0] src;
  logic [2:0] dst;
  logic [7:0] src_val;
  logic [7:0] alu_result;
  logic       taken;
  logic       stall;
  logic       dst_is_reg;

  assign opcode  = opcode_t'(dataout[7:6]);
  assign src     = dataout[5:3];
  assign dst     = dataout[2:0];
  assign address = pc_q;
  assign reg3    = regs_q[3];

  overture_alu u_alu (
    .a_i        (regs_q[1]),
    .b_i        (regs_q[2]),
    .op_i       (alu_op_t'(dataout[2:0])),
    .result_o   (alu_result),
    .cond_val_i (regs_q[3]),
    .cond_i     (cond_t'(dataout[2:0])),
    .taken_o    (taken)
  );

`ifdef OVERTURE_IO_EN
  // Input side: in_valid says in_data holds a byte; in_ready is high only in a
  // cycle where a COPY from r6 consumes it, so the transfer occurs on the edge
  // where both are high. Without in_valid that COPY stalls the whole core.
  // Output side: out_valid is a one-cycle pulse with no back-pressure.
  logic       io_read;
  logic       io_write;
  logic [7:0] out_data_q;
  logic       out_valid_q;

  assign io_read    = (opcode == OP_COPY) && (src == IO_REG);
  assign stall      = io_read && !in_valid;
  assign in_ready   = io_read && in_valid && !reset;
  assign io_write   = (opcode == OP_COPY) && (dst == IO_REG) && !stall;
  assign dst_is_reg = (dst != ZERO_REG) && (dst != IO_REG);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= io_write;
      if (io_write) out_data_q <= src_val;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
`else
  logic unused_io;

  assign unused_io  = ^{in_data, in_valid};
  assign stall      = 1'b0;
  assign in_ready   = 1'b0;
  assign out_data   = 8'h00;
  assign out_valid  = 1'b0;
  assign dst_is_reg = (dst != ZERO_REG);
`endif

  always_comb begin
    src_val = 8'h00;
    if (src != ZERO_REG) src_val = regs_q[src];
`ifdef OVERTURE_IO_EN
    if (src == IO_REG) src_val = in_data;
`endif
  end

  always_comb begin
    pc_d   = pc_q;
    regs_d = regs_q;
    if (!stall) begin
      pc_d = pc_q + 8'd1;
      case (opcode)
        OP_IMM:  regs_d[0] = {2'b00, dataout[5:0]};
        OP_CALC: regs_d[3] = alu_result;
        OP_COPY: if (dst_is_reg) regs_d[dst] = src_val;
        OP_JUMP: if (taken) pc_d = regs_q[0];
        default: pc_d = pc_q + 8'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 8'h00;
      for (int i = 0; i < 7; i++) regs_q[i] <= 8'h00;
    end else begin
      pc_q   <= pc_d;
      regs_q <= regs_d;
    end
  end

endmodule
